// File: rtl/inpdt_seq_if.sv
// Handshake and buffer-address bundle between inpdt_seq and its job master /
// buffer side. The slave modport is the sequencer's view.
interface inpdt_seq_if #(
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 12,
   parameter int ACC_W  = 32
);
   logic              iStart;
   logic [CNT_W-1:0]  iNumChunk;
   logic [CNT_W-1:0]  iNumRow;
   logic              oBusy;
   logic              oRdEn;
   logic [CNT_W-1:0]  oXH_Addr;
   logic [ADDR_W-1:0] oW_Addr;
   logic              oInpdt_En;
   logic [20:0]       iInpdt_Result;
   logic [ACC_W-1:0]  oAcc;
   logic              oAcc_Valid;
   logic              iAcc_Ready;
   logic              oDone;

   modport slave (
      input  iStart, iNumChunk, iNumRow, iInpdt_Result, iAcc_Ready,
      output oBusy, oRdEn, oXH_Addr, oW_Addr, oInpdt_En, oAcc, oAcc_Valid, oDone
   );

   modport master (
      output iStart, iNumChunk, iNumRow, iInpdt_Result, iAcc_Ready,
      input  oBusy, oRdEn, oXH_Addr, oW_Addr, oInpdt_En, oAcc, oAcc_Valid, oDone
   );
endinterface

// File: rtl/inpdt_seq.sv
// Row/chunk sequencer for the 16-lane inner-product unit: issues buffer reads,
// accumulates chunk results per row. Define INPDT_SEQ_SAT_EN for a saturating accumulator.
module inpdt_seq #(
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 12,
   parameter int ACC_W  = 32
) (
   input  logic        iClk,
   input  logic        iReset,
   inpdt_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_OUT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  num_chunk_q, num_row_q;
   logic [CNT_W-1:0]  chunk_q, row_q;
   logic [ADDR_W-1:0] w_addr_q;
   logic [ACC_W-1:0]  acc_q, acc_next, acc_base;
   logic              inpdt_en_q;
   logic              first_q;
   logic              done_zero_q;

   logic rd_en;
   logic start_ok;
   logic start_zero;
   logic last_chunk;
   logic last_row;

   assign start_ok   = bus.iStart && (bus.iNumChunk != '0) && (bus.iNumRow != '0);
   assign start_zero = bus.iStart && ((bus.iNumChunk == '0) || (bus.iNumRow == '0));
   assign last_chunk = (chunk_q == num_chunk_q - CNT_W'(1));
   assign last_row   = (row_q == num_row_q - CNT_W'(1));
   assign rd_en      = (state_q == S_RUN);

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves state_d unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_ok) state_d = S_RUN;
         S_RUN:   if (last_chunk) state_d = S_DRAIN;
         S_DRAIN: state_d = S_OUT;
         S_OUT:   if (bus.iAcc_Ready) state_d = last_row ? S_DONE : S_RUN;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q     <= S_IDLE;
         num_chunk_q <= '0;
         num_row_q   <= '0;
         chunk_q     <= '0;
         row_q       <= '0;
         w_addr_q    <= '0;
         inpdt_en_q  <= 1'b0;
         first_q     <= 1'b0;
         done_zero_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         inpdt_en_q  <= rd_en;
         first_q     <= rd_en && (chunk_q == '0);
         done_zero_q <= (state_q == S_IDLE) && start_zero;
         unique case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  num_chunk_q <= bus.iNumChunk;
                  num_row_q   <= bus.iNumRow;
                  chunk_q     <= '0;
                  row_q       <= '0;
                  w_addr_q    <= '0;
               end
            end
            S_RUN: begin
               // Weight address runs linearly across rows; chunk index restarts.
               w_addr_q <= w_addr_q + ADDR_W'(1);
               chunk_q  <= last_chunk ? '0 : chunk_q + CNT_W'(1);
            end
            S_OUT: begin
               if (bus.iAcc_Ready && !last_row) row_q <= row_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // The first chunk of a row replaces the previous row's value.
   assign acc_base = first_q ? '0 : acc_q;

`ifdef INPDT_SEQ_SAT_EN
   logic [ACC_W:0] acc_sum;
   assign acc_sum  = {1'b0, acc_base} + (ACC_W + 1)'(bus.iInpdt_Result);
   assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
   assign acc_next = acc_base + ACC_W'(bus.iInpdt_Result);
`endif

   always_ff @(posedge iClk) begin
      if (iReset) begin
         acc_q <= '0;
      end else if (inpdt_en_q) begin
         acc_q <= acc_next;
      end else if ((state_q == S_IDLE) && start_ok) begin
         acc_q <= '0;
      end
   end

   assign bus.oBusy      = (state_q != S_IDLE);
   assign bus.oRdEn      = rd_en;
   assign bus.oXH_Addr   = chunk_q;
   assign bus.oW_Addr    = w_addr_q;
   assign bus.oInpdt_En  = inpdt_en_q;
   assign bus.oAcc       = acc_q;
   assign bus.oAcc_Valid = (state_q == S_OUT);
   assign bus.oDone      = (state_q == S_DONE) || done_zero_q;

endmodule

// File: tb/tb_inpdt_seq.sv
// Scoreboard bench for inpdt_seq: stimulus queues expected reads and row
// results, a negedge monitor compares them as the DUT presents them.
module tb_inpdt_seq;

   localparam int CNT_W  = 8;
   localparam int ADDR_W = 12;

   typedef struct {
      logic [7:0]  xh;
      logic [11:0] w;
   } addr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inpdt_seq_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .ACC_W(32)) bus   ();
   inpdt_seq_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .ACC_W(21)) bus21 ();

   inpdt_seq #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .ACC_W(32)) dut (
      .iClk(clk), .iReset(rst), .bus(bus)
   );
   inpdt_seq #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .ACC_W(21)) dut21 (
      .iClk(clk), .iReset(rst), .bus(bus21)
   );

   int checks = 0;
   int passes = 0;
   int done_cnt = 0;
   logic [7:0] byte_val = 8'd0;

   addr_t       addr_q[$];
   logic [31:0] acc_exp_q[$];

   // Buffers + inpdt_16: one-cycle latency, all X/H and W bytes equal; a
   // junk value appears whenever no read was issued the cycle before.
   always @(posedge clk) begin
      bus.iInpdt_Result   <= bus.oRdEn   ? 21'(16 * byte_val * byte_val) : 21'h0ABCD;
      bus21.iInpdt_Result <= bus21.oRdEn ? 21'(16 * byte_val * byte_val) : 21'h0ABCD;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Monitor
   logic        prev_hold = 1'b0;
   logic [31:0] prev_acc  = '0;
   always @(negedge clk) begin
      addr_t e;
      if (!rst) begin
         if (bus.oRdEn) begin
            if (addr_q.size() == 0) check("unexpected_read", 1, 0);
            else begin
               e = addr_q.pop_front();
               check("xh_addr", bus.oXH_Addr, e.xh);
               check("w_addr", bus.oW_Addr, e.w);
            end
         end
         if (bus.oAcc_Valid) begin
            check("no_read_in_out", bus.oRdEn, 0);
            if (prev_hold) check("acc_stable", bus.oAcc, prev_acc);
            if (bus.iAcc_Ready) begin
               if (acc_exp_q.size() == 0) check("unexpected_row", 1, 0);
               else check("row_acc", bus.oAcc, acc_exp_q.pop_front());
            end
         end
         if (bus.oDone) done_cnt <= done_cnt + 1;
      end
      prev_hold <= bus.oAcc_Valid && !bus.iAcc_Ready && !rst;
      prev_acc  <= bus.oAcc;
   end

   task automatic start_job(input int nc, input int nr, input logic [7:0] b);
      for (int r = 0; r < nr; r++) begin
         for (int c = 0; c < nc; c++) begin
            addr_t a;
            a.xh = 8'(c);
            a.w  = 12'(r * nc + c);
            addr_q.push_back(a);
         end
         acc_exp_q.push_back(32'(nc * 16 * b * b));
      end
      @(posedge clk); #1;
      byte_val      = b;
      bus.iNumChunk = 8'(nc);
      bus.iNumRow   = 8'(nr);
      bus.iStart    = 1'b1;
      @(posedge clk); #1;
      bus.iStart    = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int first_v);
      int d0;
      bit got;
      d0 = done_cnt;
      got = 1'b0;
      first_v = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.oAcc_Valid && first_v < 0) first_v = i + 1;
         if (bus.oDone) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", got, 1);
      if (got) begin
         @(negedge clk);
         check("done_pulse_width", bus.oDone, 0);
         check("busy_cleared", bus.oBusy, 0);
         check("done_count", 64'(done_cnt - d0), 1);
      end
      check("reads_consumed", addr_q.size(), 0);
      check("rows_consumed", acc_exp_q.size(), 0);
   endtask

   initial begin
      int fv;
      int d0;
      bit seen;
      logic [20:0] exp21;

      bus.iStart = 1'b0;  bus.iNumChunk = '0;  bus.iNumRow = '0;  bus.iAcc_Ready = 1'b1;
      bus21.iStart = 1'b0; bus21.iNumChunk = '0; bus21.iNumRow = '0; bus21.iAcc_Ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", bus.oBusy, 0);
      check("reset_valid", bus.oAcc_Valid, 0);
      check("reset_acc", bus.oAcc, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Single chunk, single row, bytes of 1
      start_job(1, 1, 8'd1);
      wait_done(50, fv);
      check("first_valid_cycle", 64'(fv), 3);

      // Two rows of four chunks, bytes of 255, no backpressure
      start_job(4, 2, 8'd255);
      wait_done(100, fv);

      // Same job, row 0 held off for five cycles
      bus.iAcc_Ready = 1'b0;
      start_job(4, 2, 8'd255);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.oAcc_Valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("stall_valid_seen", seen, 1);
      repeat (4) @(negedge clk);
      @(posedge clk); #1 bus.iAcc_Ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("row1_starts_rd", bus.oRdEn, 1);
      check("row1_starts_xh", bus.oXH_Addr, 0);
      check("row1_starts_w", bus.oW_Addr, 4);
      wait_done(100, fv);

      // Zero counts: immediate done, no reads, never busy
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.iNumChunk = 8'd0; bus.iNumRow = 8'd3; bus.iStart = 1'b1;
      @(posedge clk); #1 bus.iStart = 1'b0;
      @(negedge clk);
      check("zero_chunk_done", bus.oDone, 1);
      check("zero_chunk_busy", bus.oBusy, 0);
      @(negedge clk);
      check("zero_chunk_done_end", bus.oDone, 0);
      check("zero_chunk_busy_end", bus.oBusy, 0);
      @(posedge clk); #1;
      bus.iNumChunk = 8'd2; bus.iNumRow = 8'd0; bus.iStart = 1'b1;
      @(posedge clk); #1 bus.iStart = 1'b0;
      @(negedge clk);
      check("zero_row_done", bus.oDone, 1);
      check("zero_row_busy", bus.oBusy, 0);
      @(negedge clk);
      check("zero_done_count", 64'(done_cnt - d0), 2);

      // 21-bit accumulator instance: wrap or saturate
`ifdef INPDT_SEQ_SAT_EN
      exp21 = 21'd2097151;
`else
      exp21 = 21'd2064448;
`endif
      @(posedge clk); #1;
      byte_val = 8'd255;
      bus21.iNumChunk = 8'd4; bus21.iNumRow = 8'd1; bus21.iStart = 1'b1;
      @(posedge clk); #1 bus21.iStart = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus21.oAcc_Valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("acc21_valid_seen", seen, 1);
      check("acc21_value", bus21.oAcc, exp21);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus21.oDone) begin
            seen = 1'b1;
            break;
         end
      end
      check("acc21_done", seen, 1);

      // Reset in the middle of a run, then a fresh job
      start_job(4, 2, 8'd255);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      addr_q.delete();
      acc_exp_q.delete();
      @(negedge clk);
      check("rst_busy", bus.oBusy, 0);
      check("rst_rd_en", bus.oRdEn, 0);
      check("rst_xh", bus.oXH_Addr, 0);
      check("rst_w", bus.oW_Addr, 0);
      check("rst_inpdt_en", bus.oInpdt_En, 0);
      check("rst_acc", bus.oAcc, 0);
      check("rst_valid", bus.oAcc_Valid, 0);
      check("rst_done", bus.oDone, 0);
      start_job(1, 1, 8'd1);
      wait_done(50, fv);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
      $fatal(1);
   end

endmodule

// File: doc/inpdt_seq.md
Name: inpdt_seq

Overview:
- Sequencer for the 16-lane inner-product unit (inpdt_16) in the LSTM matrix-vector datapath.
- Computes one dot product per weight row over iNumChunk 16-element chunks.
- Issues read addresses to the X/H vector buffer and the weight buffer, and gates the inner-product enable.
- Accumulates the 21-bit chunk results per row and hands each row result downstream with a valid/ready handshake.

Parameters:
- CNT_W, 8, width of the chunk and row counts.
- ADDR_W, 12, width of the weight buffer address. The X/H buffer address uses CNT_W.
- ACC_W, 32, row accumulator width. Must be ≥21.

Ports:
- iClk  input  1  clock; all logic on the rising edge.
- iReset  input  1  synchronous, active-high reset.
- iStart  input  1  single-cycle job start. Sampled only in IDLE.
- iNumChunk  input  CNT_W  chunks per row; latched on start.
- iNumRow  input  CNT_W  rows per job; latched on start.
- oBusy  output  1  high from the cycle after an accepted start until DONE.
- oRdEn  output  1  buffer read strobe; addresses are valid when high.
- oXH_Addr  output  CNT_W  X/H chunk index; restarts at 0 for every row.
- oW_Addr  output  ADDR_W  weight chunk index; linear, row*NumChunk+chunk.
- oInpdt_En  output  1  drives inpdt_16 iEn. Equals oRdEn delayed one cycle.
- iInpdt_Result  input  21  inpdt_16 oResult, treated as unsigned.
- oAcc  output  ACC_W  row dot-product result.
- oAcc_Valid  output  1  oAcc holds a complete row result.
- iAcc_Ready  input  1  downstream accepts oAcc.
- oDone  output  1  one-cycle pulse at job end.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE. A reset asserted mid-job aborts the job; nothing is retained.
- Buffers have 1-cycle read latency. Address issued in cycle t → data at inpdt_16 in cycle t+1 → accumulated at the end of cycle t+1.
- IDLE:
  - iStart with both counts nonzero → latch counts, clear the accumulator and counters, go to RUN.
  - iStart with either count zero → oDone=1 on the next cycle, no reads, remain in IDLE.
- RUN:
  - oRdEn=1 every cycle; the chunk counter and oW_Addr increment each cycle.
  - The cycle that issues chunk NumChunk-1 is the last RUN cycle; next state is DRAIN.
- DRAIN: one cycle, oRdEn=0, final chunk accumulated; next state OUT.
- Accumulation:
  - Whenever oInpdt_En=1: acc <= acc + zero-extended iInpdt_Result.
  - For the first chunk of a row: acc <= 0 + result.
  - Default overflow behaviour: wrap modulo 2^ACC_W.
- OUT:
  - oAcc_Valid=1 and oAcc held stable; no reads issued.
  - On iAcc_Ready=1, oAcc_Valid drops next cycle.
  - If the row was the last row → DONE; otherwise → RUN for the next row. oXH_Addr restarts at 0; oW_Addr continues.
- DONE: oDone=1 for one cycle, oBusy=0 from the following cycle, return to IDLE.
- Latency per row: NumChunk+2 cycles minimum, plus any backpressure stall. There is no overlap between rows.
- iStart while not in IDLE is ignored.
- oW_Addr wraps naturally at 2^ADDR_W. Sizing the job within the buffer is the software's responsibility.
- oXH_Addr is the chunk counter, 0..NumChunk-1.

Optional Feature:
- Macro INPDT_SEQ_SAT_EN.
- Defined: the accumulate step saturates to {ACC_W{1'b1}} instead of wrapping, and the value stays saturated until the row is accepted.
- Undefined: modulo-2^ACC_W wrap; no saturation logic is synthesised.

Test Plan:
- NumChunk=1, NumRow=1, all X/H and W bytes 1 → one read at addresses 0/0, oAcc=16, oAcc_Valid in cycle 3 after start, then an oDone pulse.
- NumChunk=4, NumRow=2, all bytes 255, iAcc_Ready=1:
  - oW_Addr sequence 0..3 then 4..7; oXH_Addr sequence 0..3 twice.
  - Each oAcc=4161600; one oDone pulse.
- Same job with iAcc_Ready held low 5 cycles on row 0 → oAcc/oAcc_Valid stable and oRdEn=0 throughout. Row 1 starts the cycle after acceptance.
- iStart with iNumChunk=0 → oDone pulse next cycle, oRdEn never asserted, oBusy stays 0.
- ACC_W=21, NumChunk=4, bytes 255:
  - With INPDT_SEQ_SAT_EN → oAcc=2097151.
  - Without it → oAcc=2064448.
- Assert iReset for 1 cycle mid-RUN → all outputs 0 next cycle. A fresh start with NumChunk=1, NumRow=1 and bytes 1 gives oAcc=16.
